// File: rtl/rom_streamer.sv
// Sequential ROM reader: sweeps LEN words from BASE through a fixed 2-cycle read pipe
// into a small FIFO, and presents them as a valid/ready stream with a last flag.
module rom_streamer #(
  parameter int WIDTH      = 32,
  parameter int ADDRW      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   length,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = PW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                           state_q, state_d;
  logic [ADDRW-1:0]                 addr_q, addr_d;
  logic [ADDRW:0]                   rem_q, rem_d;
  logic [1:0]                       vld_pipe_q, vld_pipe_d;
  logic [1:0]                       last_pipe_q, last_pipe_d;
  logic [FIFO_DEPTH-1:0][WIDTH-1:0] data_mem_q, data_mem_d;
  logic [FIFO_DEPTH-1:0]            last_mem_q, last_mem_d;
  logic [PW-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                    count_q, count_d;
  logic                             busy_q, busy_d, done_q, done_d;

  logic          pop, push, issue, issue_last, credit_ok;
  logic [SW-1:0] occupancy;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    data_mem_d  = data_mem_q;
    last_mem_d  = last_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;

    pop  = (count_q != '0) && m_ready;
    push = vld_pipe_q[1];
    // Words already committed (FIFO + in flight) minus the one leaving this cycle.
    occupancy = SW'(count_q) + SW'(vld_pipe_q[0]) + SW'(vld_pipe_q[1]) - SW'(pop);
    credit_ok = occupancy < SW'(FIFO_DEPTH);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            issue      = 1'b1;
            addr_d     = base_addr;
            rem_d      = length - (ADDRW+1)'(1);
            issue_last = (length == (ADDRW+1)'(1));
            state_d    = issue_last ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue      = 1'b1;
          addr_d     = addr_q + ADDRW'(1);
          rem_d      = rem_q - (ADDRW+1)'(1);
          issue_last = (rem_q == (ADDRW+1)'(1));
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_mem_q[rd_ptr_q]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    vld_pipe_d  = {vld_pipe_q[0], issue};
    last_pipe_d = {last_pipe_q[0], issue_last};

    if (push) begin
      data_mem_d[wr_ptr_q] = rom_data;
      last_mem_d[wr_ptr_q] = last_pipe_q[1];
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      data_mem_q  <= '0;
      last_mem_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      data_mem_q  <= data_mem_d;
      last_mem_q  <= last_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign m_valid  = (count_q != '0);
  assign m_data   = data_mem_q[rd_ptr_q];
  // Gate with valid so a stale tail entry never shows last on an empty FIFO.
  assign m_last   = m_valid && last_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_rom_streamer.sv
// Directed bench for rom_streamer: registered ROM model mem[i]=i, scoreboard of expected
// words pushed at start and popped on each stream handshake.
module tb_rom_streamer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] length = '0;
  logic        busy, done;
  logic [11:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {logic [31:0] d; logic l;} exp_t;
  exp_t sb[$];
  exp_t e;

  rom_streamer #(.WIDTH(32), .ADDRW(12), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // Registered ROM, contents mem[i] = i
  always @(posedge clk) rom_data <= 32'(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Stream monitor: hold-stability and scoreboard compare on every handshake
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", m_data, pd);
        chk("hold_last", 32'(m_last), 32'(pl));
      end
      if (m_valid && m_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("data", m_data, e.d);
          chk("last", 32'(m_last), 32'(e.l));
        end
      end
    end
    pv = m_valid && !rst;
    pr = m_ready;
    pd = m_data;
    pl = m_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input int b, input int l);
    exp_t x;
    for (int i = 0; i < l; i++) begin
      x.d = 32'((b + i) % 4096);
      x.l = (i == l - 1);
      sb.push_back(x);
    end
    base_addr = 12'(b);
    length    = 13'(l);
    start     = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
  endtask

  // mode 0: m_ready held high; mode 1: random ready, 10-cycle stall, stray start pulse
  task automatic wait_done(input int mode, input int budget);
    while (!done && cyc < budget) begin
      if (mode == 1) begin
        m_ready   = (cyc >= 6 && cyc < 16) ? 1'b0 : 1'($urandom_range(0, 1));
        start     = (cyc == 3);
        base_addr = 12'd100;
        length    = 13'd3;
      end
      tick();
      cyc++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    chk({tag, "_m_data"}, m_data, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic sweep, back-to-back stream
    start_sweep(5, 4);
    chk("t1_rom_addr0", 32'(rom_addr), 32'd5);
    chk("t1_valid_e0", 32'(m_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick(); cyc++;
    chk("t1_valid_e1", 32'(m_valid), 32'd0);
    tick(); cyc++;
    chk("t1_valid_e2", 32'(m_valid), 32'd1);
    chk("t1_first_data", m_data, 32'd5);
    wait_done(0, 100);
    chk("t1_latency", 32'(cyc), 32'd7);
    chk("t1_busy_at_done", 32'(busy), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // Address wrap
    start_sweep(4094, 4);
    chk("t2_addr0", 32'(rom_addr), 32'd4094);
    tick(); cyc++;
    chk("t2_addr1", 32'(rom_addr), 32'd4095);
    tick(); cyc++;
    chk("t2_addr2", 32'(rom_addr), 32'd0);
    tick(); cyc++;
    chk("t2_addr3", 32'(rom_addr), 32'd1);
    wait_done(0, 100);
    chk("t2_latency", 32'(cyc), 32'd7);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // Backpressure with a long stall and a start pulse mid-sweep
    start_sweep(16, 16);
    wait_done(1, 400);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_done_low", 32'(done), 32'd0);
    chk("t3_busy_after", 32'(busy), 32'd0);
    chk("t3_valid_after", 32'(m_valid), 32'd0);

    // Zero-length start
    start_sweep(7, 0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(m_valid), 32'd0);
    tick();
    chk("t4_done_low", 32'(done), 32'd0);
    chk("t4_valid_low", 32'(m_valid), 32'd0);
    chk("t4_busy_low", 32'(busy), 32'd0);

    // Reset mid-sweep, then a fresh short sweep
    start_sweep(0, 8);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    sb.delete();
    tick();
    chk("t5_no_done", 32'(done), 32'd0);
    start_sweep(0, 2);
    wait_done(0, 50);
    chk("t5_latency", 32'(cyc), 32'd5);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // Full-ROM sweep
    start_sweep(0, 4096);
    wait_done(0, 5000);
    chk("t6_latency", 32'(cyc), 32'd4099);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
